// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: streaming test-pattern source, one header beat then W*H pixels.
// Define VPG_CTRL_PKT_EN to prepend a 10-beat control packet to every frame.
module vid_pattern_gen #(
    parameter int              DW        = 8,
    parameter int              W         = 1920,
    parameter int              H         = 1080,
    parameter logic [DW-1:0]   PIX_CONST = DW'(8'h55),
    parameter int              CHK_SHIFT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    output logic [DW-1:0] src_data,
    output logic          src_valid,
    output logic          src_sop,
    output logic          src_eop,
    input  logic          src_ready,
    output logic          frame_done,
    output logic [15:0]   frame_cnt
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef VPG_CTRL_PKT_EN
        CTRL = 2'd1,
`endif
        HDR  = 2'd2,
        PIX  = 2'd3
    } state_e;

`ifdef VPG_CTRL_PKT_EN
    localparam state_e        FIRST_ST   = CTRL;
    localparam logic [DW-1:0] FIRST_DATA = DW'(4'hF);
    localparam logic [15:0]   W16        = 16'(W);
    localparam logic [15:0]   H16        = 16'(H);

    // Beat i (1..9) of the control packet: W then H, MSB nibble first, then 0.
    function automatic logic [3:0] ctrl_nib(input logic [3:0] i);
        logic [3:0] r;
        r = 4'h0;
        unique case (i)
            4'd1: r = W16[15:12];
            4'd2: r = W16[11:8];
            4'd3: r = W16[7:4];
            4'd4: r = W16[3:0];
            4'd5: r = H16[15:12];
            4'd6: r = H16[11:8];
            4'd7: r = H16[7:4];
            4'd8: r = H16[3:0];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    logic [3:0] ctrl_idx_q, ctrl_idx_d;
`else
    localparam state_e        FIRST_ST   = HDR;
    localparam logic [DW-1:0] FIRST_DATA = '0;
`endif

    function automatic logic [DW-1:0] pix_val(input logic [1:0]    m,
                                              input logic [XW-1:0] px,
                                              input logic [YW-1:0] py);
        logic [31:0]   xe;
        logic [31:0]   ye;
        logic [DW-1:0] r;
        xe = 32'(px);
        ye = 32'(py);
        unique case (m)
            2'd0:    r = PIX_CONST;
            2'd1:    r = DW'(xe);
            2'd2:    r = DW'(ye);
            default: r = (xe[CHK_SHIFT] ^ ye[CHK_SHIFT]) ? '1 : '0;
        endcase
        return r;
    endfunction

    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic [DW-1:0]   data_q, data_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      mode_q, mode_d;
    logic            done_q, done_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            xfer;
    logic            start;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;

    assign xfer = valid_q & src_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        data_d  = data_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        start   = 1'b0;
        nx      = x_q;
        ny      = y_q;
`ifdef VPG_CTRL_PKT_EN
        ctrl_idx_d = ctrl_idx_q;
`endif
        unique case (state_q)
            IDLE: start = enable;
`ifdef VPG_CTRL_PKT_EN
            CTRL: begin
                if (xfer) begin
                    if (ctrl_idx_q == 4'd9) begin
                        state_d = HDR;
                        data_d  = '0;
                        sop_d   = 1'b1;
                        eop_d   = 1'b0;
                    end else begin
                        ctrl_idx_d = ctrl_idx_q + 4'd1;
                        data_d     = DW'(ctrl_nib(ctrl_idx_q + 4'd1));
                        sop_d      = 1'b0;
                        eop_d      = (ctrl_idx_q == 4'd8);
                    end
                end
            end
`endif
            HDR: begin
                if (xfer) begin
                    mode_d  = mode;
                    state_d = PIX;
                    x_d     = '0;
                    y_d     = '0;
                    data_d  = pix_val(mode, '0, '0);
                    sop_d   = 1'b0;
                    eop_d   = (X_LAST == '0) && (Y_LAST == '0);
                end
            end
            PIX: begin
                if (xfer) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        x_d    = '0;
                        y_d    = '0;
                        start  = enable;
                        if (!enable) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                        end
                    end else begin
                        if (x_q == X_LAST) begin
                            nx = '0;
                            ny = y_q + 1'b1;
                        end else begin
                            nx = x_q + 1'b1;
                        end
                        x_d    = nx;
                        y_d    = ny;
                        data_d = pix_val(mode_q, nx, ny);
                        eop_d  = (nx == X_LAST) && (ny == Y_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = FIRST_ST;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            data_d  = FIRST_DATA;
`ifdef VPG_CTRL_PKT_EN
            ctrl_idx_d = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 2'd0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
`ifdef VPG_CTRL_PKT_EN
            ctrl_idx_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
`ifdef VPG_CTRL_PKT_EN
            ctrl_idx_q <= ctrl_idx_d;
`endif
        end
    end

    assign src_data   = data_q;
    assign src_valid  = valid_q;
    assign src_sop    = sop_q;
    assign src_eop    = eop_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: randomized stream check of vid_pattern_gen (W=4, H=2).
// Follows VPG_CTRL_PKT_EN to expect the control packet when it is defined.
module tb_vid_pattern_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CS = 0;
`ifdef VPG_CTRL_PKT_EN
    localparam int LC = 10;
`else
    localparam int LC = 0;
`endif
    localparam int PIX0 = LC + 1;
    localparam int FLEN = LC + 1 + W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_sop;
    logic          src_eop;
    logic          src_ready;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    vid_pattern_gen #(
        .DW(DW), .W(W), .H(H), .PIX_CONST(8'h55), .CHK_SHIFT(CS)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .src_data(src_data), .src_valid(src_valid),
        .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beat k of a frame as {eop, sop, data}.
    function automatic logic [9:0] exp_beat(input int kk, input logic [1:0] m);
        int i, f, sh, p, x, y;
        logic [7:0] d;
        logic sop, eop;
        d = 8'h00; sop = 1'b0; eop = 1'b0;
        if (kk < LC) begin
            sop = (kk == 0);
            eop = (kk == LC - 1);
            if (kk == 0) d = 8'h0F;
            else begin
                i  = kk - 1;
                f  = (i < 4) ? W : ((i < 8) ? H : 0);
                sh = 12 - 4 * (i % 4);
                d  = 8'((f >> sh) & 15);
            end
        end else if (kk == LC) begin
            sop = 1'b1;
        end else begin
            p = kk - PIX0;
            x = p % W;
            y = p / W;
            eop = (p == W * H - 1);
            case (m)
                2'd0: d = 8'h55;
                2'd1: d = 8'(x);
                2'd2: d = 8'(y);
                default: d = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 8'hFF : 8'h00;
            endcase
        end
        return {eop, sop, d};
    endfunction

    // Reference state: what the DUT presents after the next posedge.
    logic       mon_on  = 1'b0;
    logic       idle    = 1'b1;
    int         k       = 0;
    logic [15:0] cnt    = 16'd0;
    logic       fd_pend = 1'b0;
    logic [1:0] fmode   = 2'd0;
    int         frames  = 0;
    logic [9:0] e;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid", {31'd0, src_valid}, {31'd0, !idle});
            chk("frame_done", {31'd0, frame_done}, {31'd0, fd_pend});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, cnt});
            if (!idle && src_valid) begin
                e = exp_beat(k, fmode);
                chk("data", {24'd0, src_data}, {24'd0, e[7:0]});
                chk("sop", {31'd0, src_sop}, {31'd0, e[8]});
                chk("eop", {31'd0, src_eop}, {31'd0, e[9]});
            end
            fd_pend = 1'b0;
            if (rst) begin
                idle = 1'b1;
                k    = 0;
                cnt  = 16'd0;
            end else if (idle) begin
                if (enable) begin
                    idle = 1'b0;
                    k    = 0;
                end
            end else if (src_valid && src_ready) begin
                if (k == LC) fmode = mode;
                if (k == FLEN - 1) begin
                    fd_pend = 1'b1;
                    cnt     = cnt + 16'd1;
                    frames++;
                    k = 0;
                    if (!enable) idle = 1'b1;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_beat(input int kk);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = !idle && (k == kk);
        end
        chk("wait_beat", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_frames(input int n);
        int target;
        target = frames + n;
        for (int i = 0; i < 100 * n + 100 && frames < target; i++) step();
        chk("wait_frames", {31'd0, frames >= target}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && !idle; i++) step();
        chk("wait_idle", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        mode      = 2'd0;
        src_ready = 1'b1;
        step();
        step();
        mon_on = 1'b1;
        rst    = 1'b0;
        step();

        // Each mode in turn; a change mid-frame applies from the next header.
        enable = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            wait_frames(1);
            wait_beat(PIX0 + 3);
            mode = 2'(m + 1);
        end
        wait_frames(1);

        // Sink stall while pixel 5 is presented.
        wait_beat(PIX0 + 5);
        src_ready = 1'b0;
        step();
        step();
        step();
        chk("stall_hold", {31'd0, src_valid}, 32'd1);
        src_ready = 1'b1;
        wait_frames(1);

        // Enable dropped mid-frame: frame completes, then silence.
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        wait_beat(PIX0 + 2);
        enable = 1'b0;
        wait_idle();
        repeat (10) step();
        chk("cnt_after_drop", {16'd0, frame_cnt}, 32'd1);

        // Reset in the middle of a frame.
        enable = 1'b1;
        wait_beat(PIX0 + 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", {31'd0, src_valid}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        wait_frames(1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            src_ready = ($urandom_range(0, 9) < 7);
            enable    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst       = 1'b0;
        src_ready = 1'b1;
        enable    = 1'b0;
        wait_idle();
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
